// File: rtl/alsu_cmd_scheduler.sv
// Shares one ALSU between two command requesters: round-robin arbitration with an idle-timed lock,
// one issue per cycle into the ALSU pipeline, and in-order response return to the issuer.
module alsu_cmd_scheduler #(
  parameter int unsigned LOCK_TIMEOUT = 8,
  parameter int unsigned ALSU_LAT     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_lock,
  input  logic [15:0] req0_cmd,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_lock,
  input  logic [15:0] req1_cmd,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [5:0]  rsp_data,
  output logic [15:0] rsp_leds,
  output logic        rsp_err,
  output logic [2:0]  alsu_A,
  output logic [2:0]  alsu_B,
  output logic [2:0]  alsu_opcode,
  output logic        alsu_cin,
  output logic        alsu_serial_in,
  output logic        alsu_direction,
  output logic        alsu_red_op_A,
  output logic        alsu_red_op_B,
  output logic        alsu_bypass_A,
  output logic        alsu_bypass_B,
  input  logic [5:0]  alsu_out,
  input  logic [15:0] alsu_leds
);

  localparam int unsigned Depth       = ALSU_LAT + 1;
  localparam logic [7:0]  TimeoutLast = 8'(LOCK_TIMEOUT - 1);
  // Both bypasses set with zero operands: ALSU out goes to 0, leds untouched.
  localparam logic [15:0] IdlePattern = 16'h0003;

  typedef enum logic {StFree, StLocked} state_e;

  state_e      state_q;
  logic        owner_q;
  logic [7:0]  idle_cnt_q;
  logic        rr_last_q;
  logic [15:0] issue_q;
  logic [Depth-1:0] trk_valid_q;
  logic [Depth-1:0] trk_id_q;
  logic [Depth-1:0] trk_err_q;

  logic        gnt0, gnt1, hs, hs_id, hs_lock, hs_err;
  logic [15:0] hs_cmd;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StLocked) begin
      gnt0 = !owner_q && req0_valid;
      gnt1 = owner_q && req1_valid;
    end else if (req0_valid && req1_valid) begin
      gnt0 = rr_last_q;
      gnt1 = !rr_last_q;
    end else begin
      gnt0 = req0_valid;
      gnt1 = req1_valid;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign hs         = gnt0 | gnt1;
  assign hs_id      = gnt1;
  assign hs_cmd     = gnt1 ? req1_cmd : req0_cmd;
  assign hs_lock    = gnt1 ? req1_lock : req0_lock;

  // Fields: A[15:13] B[12:10] op[9:7] cin[6] serial_in[5] direction[4] red_A[3] red_B[2]
  // bypass_A[1] bypass_B[0].
  always_comb begin
    hs_err = !(hs_cmd[1] || hs_cmd[0]) &&
             ((hs_cmd[9:7] >= 3'd6) || ((hs_cmd[3] || hs_cmd[2]) && (hs_cmd[9:7] >= 3'd2)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StFree;
      owner_q    <= 1'b0;
      idle_cnt_q <= 8'd0;
      rr_last_q  <= 1'b1;
    end else begin
      if (hs) rr_last_q <= hs_id;
      unique case (state_q)
        StFree: begin
          if (hs && hs_lock) begin
            state_q    <= StLocked;
            owner_q    <= hs_id;
            idle_cnt_q <= 8'd0;
          end
        end
        StLocked: begin
          if (hs) begin
            idle_cnt_q <= 8'd0;
            if (!hs_lock) state_q <= StFree;
          end else if (idle_cnt_q == TimeoutLast) begin
            idle_cnt_q <= 8'd0;
            state_q    <= StFree;
          end else begin
            idle_cnt_q <= idle_cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_q     <= IdlePattern;
      trk_valid_q <= '0;
      trk_id_q    <= '0;
      trk_err_q   <= '0;
    end else begin
      issue_q     <= hs ? hs_cmd : IdlePattern;
      trk_valid_q <= {trk_valid_q[Depth-2:0], hs};
      trk_id_q    <= {trk_id_q[Depth-2:0], hs_id & hs};
      trk_err_q   <= {trk_err_q[Depth-2:0], hs_err & hs};
    end
  end

  assign alsu_A         = issue_q[15:13];
  assign alsu_B         = issue_q[12:10];
  assign alsu_opcode    = issue_q[9:7];
  assign alsu_cin       = issue_q[6];
  assign alsu_serial_in = issue_q[5];
  assign alsu_direction = issue_q[4];
  assign alsu_red_op_A  = issue_q[3];
  assign alsu_red_op_B  = issue_q[2];
  assign alsu_bypass_A  = issue_q[1];
  assign alsu_bypass_B  = issue_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 6'd0;
      rsp_leds  <= 16'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= trk_valid_q[Depth-1];
      if (trk_valid_q[Depth-1]) begin
        rsp_id   <= trk_id_q[Depth-1];
        rsp_err  <= trk_err_q[Depth-1];
        rsp_data <= alsu_out;
        rsp_leds <= alsu_leds;
      end
    end
  end

endmodule

// File: tb/tb_alsu_cmd_scheduler.sv
// Bench for alsu_cmd_scheduler: ALSU stub, transaction-level arbitration/response model,
// directed scenarios with hand-computed literals.
module tb_alsu_cmd_scheduler;

  localparam int unsigned LockTimeout = 8;
  localparam logic [15:0] Idle = 16'h0003;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req0_lock;
  logic [15:0] req0_cmd;
  logic        req1_valid, req1_ready, req1_lock;
  logic [15:0] req1_cmd;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [5:0]  rsp_data;
  logic [15:0] rsp_leds;
  logic [2:0]  alsu_A, alsu_B, alsu_opcode;
  logic        alsu_cin, alsu_serial_in, alsu_direction;
  logic        alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;

  alsu_cmd_scheduler #(.LOCK_TIMEOUT(LockTimeout), .ALSU_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_lock(req0_lock),
    .req0_cmd(req0_cmd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_lock(req1_lock),
    .req1_cmd(req1_cmd),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_leds(rsp_leds),
    .rsp_err(rsp_err),
    .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode), .alsu_cin(alsu_cin),
    .alsu_serial_in(alsu_serial_in), .alsu_direction(alsu_direction),
    .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
    .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
    .alsu_out(alsu_out), .alsu_leds(alsu_leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALSU behaviour: {invalid, out} for one command given the previous out.
  function automatic logic [6:0] alsu_f(input logic [15:0] c, input logic [5:0] prev);
    logic [2:0] a, b, op;
    logic cin, sin, dir, ra, rb, ba, bb, inv;
    logic [5:0] o;
    {a, b, op, cin, sin, dir, ra, rb, ba, bb} = c;
    inv = !(ba || bb) && (op >= 3'd6 || ((ra || rb) && op >= 3'd2));
    o = 6'd0;
    if (ba) o = {3'b0, a};
    else if (bb) o = {3'b0, b};
    else if (!inv) begin
      case (op)
        3'd0: o = ra ? {5'b0, &a} : rb ? {5'b0, &b} : {3'b0, a & b};
        3'd1: o = ra ? {5'b0, ^a} : rb ? {5'b0, ^b} : {3'b0, a ^ b};
        3'd2: o = {3'b0, a} + {3'b0, b} + {5'b0, cin};
        3'd3: o = {3'b0, a} * {3'b0, b};
        3'd4: o = dir ? {prev[4:0], sin} : {sin, prev[5:1]};
        3'd5: o = dir ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
        default: o = 6'd0;
      endcase
    end
    return {inv, o};
  endfunction

  // ALSU stub: input register stage then output/leds register stage.
  logic [15:0] stub_in_q, stub_leds_q, dut_issue;
  logic [5:0]  stub_out_q;
  logic [6:0]  stub_r;
  assign dut_issue = {alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in, alsu_direction,
                      alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B};
  assign stub_r    = alsu_f(stub_in_q, stub_out_q);
  assign alsu_out  = stub_out_q;
  assign alsu_leds = stub_leds_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_in_q   <= Idle;
      stub_out_q  <= 6'd0;
      stub_leds_q <= 16'd0;
    end else begin
      stub_in_q  <= dut_issue;
      stub_out_q <= stub_r[5:0];
      if (stub_r[6]) stub_leds_q <= ~stub_leds_q;
    end
  end

  typedef struct packed {logic v; logic id; logic err; logic [5:0] d; logic [15:0] l;} rsp_t;
  typedef struct packed {logic id; logic err; logic [5:0] d; logic [15:0] l; logic lchk;} lit_t;

  int n_chk = 0, n_err = 0, stall0 = 0;
  logic [16:0] q0[$], q1[$];
  lit_t lit_q[$];

  // Model state.
  logic        m_rr_last, m_locked, m_owner;
  int          m_idle;
  logic [5:0]  m_prev;
  logic [15:0] m_leds, m_alsu;
  rsp_t        m_pipe[3];
  rsp_t        m_cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] a, b, op, input logic [6:0] flags);
    return {a, b, op, flags};
  endfunction

  task automatic model_reset();
    m_rr_last = 1'b1; m_locked = 1'b0; m_owner = 1'b0; m_idle = 0;
    m_prev = 6'd0; m_leds = 16'd0; m_alsu = Idle; m_cur = '0;
    for (int i = 0; i < 3; i++) m_pipe[i] = '0;
  endtask

  task automatic step();
    logic v0, v1, g_ok, g, lk;
    logic [16:0] ent;
    logic [15:0] issued;
    logic [6:0] r;
    lit_t lt;
    @(negedge clk);
    v0 = q0.size() != 0;
    v1 = q1.size() != 0;
    req0_valid = v0; req0_lock = v0 ? q0[0][16] : 1'b0; req0_cmd = v0 ? q0[0][15:0] : 16'h0;
    req1_valid = v1; req1_lock = v1 ? q1[0][16] : 1'b0; req1_cmd = v1 ? q1[0][15:0] : 16'h0;
    if (m_locked) begin g = m_owner; g_ok = m_owner ? v1 : v0; end
    else if (v0 && v1) begin g = ~m_rr_last; g_ok = 1'b1; end
    else begin g = v1 && !v0; g_ok = v0 || v1; end
    #1;
    chk("req0_ready", req0_ready, g_ok && !g);
    chk("req1_ready", req1_ready, g_ok && g);
    chk("alsu_drive", dut_issue, m_alsu);
    chk("rsp_valid", rsp_valid, m_cur.v);
    if (m_cur.v) begin
      chk("rsp_id", rsp_id, m_cur.id);
      chk("rsp_data", rsp_data, m_cur.d);
      chk("rsp_err", rsp_err, m_cur.err);
      chk("rsp_leds", rsp_leds, m_cur.l);
      n_chk++;
      if (lit_q.size() == 0) begin
        n_err++;
        $display("FAIL lit_missing: got response id %0d expected none", m_cur.id);
      end else begin
        lt = lit_q.pop_front();
        chk("lit_id", m_cur.id, lt.id);
        chk("lit_data", m_cur.d, lt.d);
        chk("lit_err", m_cur.err, lt.err);
        if (lt.lchk) chk("lit_leds", m_cur.l, lt.l);
      end
    end
    if (req0_valid && !req0_ready) stall0++;
    @(posedge clk);
    if (g_ok) begin
      ent = g ? q1.pop_front() : q0.pop_front();
      lk = ent[16];
      issued = ent[15:0];
      m_rr_last = g;
      if (m_locked) begin m_idle = 0; if (!lk) m_locked = 1'b0; end
      else if (lk) begin m_locked = 1'b1; m_owner = g; m_idle = 0; end
    end else begin
      issued = Idle;
      if (m_locked) begin
        m_idle++;
        if (m_idle == LockTimeout) m_locked = 1'b0;
      end
    end
    m_alsu = issued;
    r = alsu_f(issued, m_prev);
    m_prev = r[5:0];
    if (r[6]) m_leds = ~m_leds;
    m_cur = m_pipe[2];
    m_pipe[2] = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = '{v: g_ok, id: g_ok & g, err: g_ok & r[6], d: r[5:0], l: m_leds};
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    q0.delete(); q1.delete();
    model_reset();
    #1;
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_data, rsp_leds, rsp_err}, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_alsu", dut_issue, Idle);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic lit(input logic id, input logic [5:0] d, input logic err, input logic [15:0] l,
                     input logic lchk);
    lit_q.push_back('{id: id, err: err, d: d, l: l, lchk: lchk});
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 1'b0; req0_lock = 1'b0; req0_cmd = 16'h0;
    req1_valid = 1'b0; req1_lock = 1'b0; req1_cmd = 16'h0;
    #2;
    do_reset();

    // Single add with carry.
    q0.push_back({1'b0, mk(3'd3, 3'd5, 3'd2, 7'b1000000)}); lit(0, 6'd9, 0, 0, 0);
    run(6);

    // Both valid from reset: requester 0 first.
    do_reset();
    q0.push_back({1'b0, mk(3'd7, 3'd7, 3'd3, 7'b0)}); lit(0, 6'd49, 0, 0, 0);
    q1.push_back({1'b0, mk(3'd6, 3'd3, 3'd1, 7'b0)}); lit(1, 6'd5, 0, 0, 0);
    run(7);

    // Locked shift chain by requester 1; requester 0 waits for the release.
    q1.push_back({1'b1, mk(3'd5, 3'd0, 3'd0, 7'b0000010)}); lit(1, 6'd5, 0, 0, 0);
    q1.push_back({1'b1, mk(3'd0, 3'd0, 3'd4, 7'b0110000)}); lit(1, 6'd11, 0, 0, 0);
    q1.push_back({1'b0, mk(3'd0, 3'd0, 3'd4, 7'b0110000)}); lit(1, 6'd23, 0, 0, 0);
    run(1);
    q0.push_back({1'b0, mk(3'd1, 3'd2, 3'd2, 7'b0)}); lit(0, 6'd3, 0, 0, 0);
    run(8);

    // Lock taken then owner idles: requester 0 stalls for the timeout.
    stall0 = 0;
    q1.push_back({1'b1, mk(3'd2, 3'd1, 3'd2, 7'b0)}); lit(1, 6'd3, 0, 0, 0);
    run(1);
    q0.push_back({1'b0, mk(3'd4, 3'd1, 3'd1, 7'b0)}); lit(0, 6'd5, 0, 0, 0);
    run(14);
    chk("lock_stall", stall0, 8);

    // Invalid commands: out 0, err set, leds toggle.
    q0.push_back({1'b0, mk(3'd0, 3'd0, 3'd7, 7'b0)}); lit(0, 6'd0, 1, 16'hFFFF, 1);
    q0.push_back({1'b0, mk(3'd0, 3'd0, 3'd7, 7'b0)}); lit(0, 6'd0, 1, 16'h0000, 1);
    q0.push_back({1'b0, mk(3'd5, 3'd3, 3'd2, 7'b0001000)}); lit(0, 6'd0, 1, 16'hFFFF, 1);
    run(8);

    // Reset with a command in flight: dropped, then requester 0 wins first.
    q0.push_back({1'b0, mk(3'd1, 3'd2, 3'd2, 7'b0)});
    run(2);
    do_reset();
    q0.push_back({1'b0, mk(3'd2, 3'd2, 3'd2, 7'b0)}); lit(0, 6'd4, 0, 0, 0);
    q1.push_back({1'b0, mk(3'd3, 3'd3, 3'd2, 7'b0)}); lit(1, 6'd6, 0, 0, 0);
    run(8);

    chk("lit_left", lit_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alsu_cmd_scheduler.md
# alsu_cmd_scheduler

Shares one ALSU datapath between two command requesters. Arbitrates round-robin, with an optional lock so a requester can chain shift/rotate commands. Issues at most one command per cycle into the ALSU's two-stage register pipeline and returns each 6-bit result, LED state and error flag to the issuing requester. Sits between the requester logic and the ALSU instance; the ALSU shares clk and rst.

## Interface
- LOCK_TIMEOUT, 8: owner-idle cycles (1..255) after which a held lock is released.
- ALSU_LAT, 2: clock edges from ALSU input capture to a valid ALSU out (datapath is built with 2).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- reqN_valid, N=0,1  in  1  command valid.
- reqN_ready, N=0,1  out  1  command accepted this cycle; combinational, may depend on reqN_valid.
- reqN_lock, N=0,1  in  1  request/keep exclusive ownership after this command.
- reqN_cmd, N=0,1  in  16  command fields, MSB first: {A[2:0], B[2:0], opcode[2:0], cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B}.
- rsp_valid  out  1  single-cycle response pulse; no backpressure.
- rsp_id  out  1  index of the requester that issued the command.
- rsp_data  out  6  ALSU out for the command.
- rsp_leds  out  16  ALSU leds sampled with rsp_data.
- rsp_err  out  1  command was invalid.
- alsu_A, alsu_B, alsu_opcode  out  3 each  registered drive to the ALSU.
- alsu_cin, alsu_serial_in, alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B  out  1 each  registered drive to the ALSU.
- alsu_out  in  6 / alsu_leds  in  16  ALSU results.

## Operation
- Handshake: reqN_valid && reqN_ready at a rising edge. At most one requester gets ready per cycle. Requesters hold valid and cmd stable until accepted and must not gate valid on ready.
- Arbitration state: rr_last (last served, reset 1, so requester 0 wins first) and FSM {FREE, LOCKED} with owner and idle_cnt[7:0].
- FREE: grant the single valid requester. If both are valid, grant the one that is not rr_last. Update rr_last on each handshake.
- FREE to LOCKED: on a handshake with reqN_lock=1. owner=N, idle_cnt=0.
- LOCKED: only the owner can get ready; the other requester is stalled.
  - Owner handshake with lock=1: stay LOCKED, idle_cnt=0.
  - Owner handshake with lock=0: go to FREE. This command is still issued.
  - Cycle without an owner handshake: idle_cnt+1. When idle_cnt reaches LOCK_TIMEOUT, go to FREE; normal arbitration applies from the next cycle.
- Issue: on a handshake, alsu_* are loaded from the command at that edge.
- Idle pattern: with no handshake, alsu_* are loaded with A=B=0, opcode=0, bypass_A=bypass_B=1, all other fields 0. This drives ALSU out to 0 and leaves leds unchanged.
- Chaining: shift/rotate work on the previous ALSU out. They chain correctly only when commands are accepted on consecutive cycles. An idle cycle, even while LOCKED, clears the chain base to 0.
- Error: err=1 if !(bypass_A||bypass_B) and either opcode is 6 or 7, or (red_op_A||red_op_B) with opcode not 0 or 1. The command is still issued; ALSU returns 0 and toggles leds. Computed at issue and carried through the pipeline.
- Tracking pipeline: ALSU_LAT+1 stages of {valid, id, err}, shifted every cycle. Idle issues enter as valid=0.

## Timing
- Handshake at edge E0: alsu_* update at E0. ALSU input registers capture at E1. alsu_out is valid between E2 and E3. Scheduler samples at E3.
- rsp_valid, rsp_id, rsp_data, rsp_leds, rsp_err are registered and valid in the cycle after E3, for exactly one cycle.
- Throughput: one command per cycle. Responses return in acceptance order, one per cycle.
- Reset values: all outputs 0. alsu_* hold the idle pattern. FSM FREE, pipeline empty.
- Reset mid-operation: in-flight commands are dropped; no rsp_valid is produced for them.
- Simultaneous events: a lock release and the other requester's valid in the same cycle give ready only to the owner; the other requester is granted from the next cycle.

## Test plan
- req0 cmd A=3, B=5, op=2, cin=1 accepted at E0 -> rsp_valid one cycle after E3: rsp_id=0, rsp_data=9, rsp_err=0.
- req0 and req1 valid together from reset: req0 A=7, B=7, op=3; req1 A=6, B=3, op=1 -> req0 accepted first, then req1 -> consecutive responses: data 49 (id 0), then data 5 (id 1).
- req1 locked chain, consecutive cycles: bypass_A with A=5, then op=4, direction=1, serial_in=1 -> data 5, then data 11. req0 held valid throughout and not granted until req1 sends lock=0.
- req1 takes the lock, then stays idle with req0 valid -> req0_ready=0 for LOCK_TIMEOUT=8 cycles, then req0 is granted.
- op=7 with no bypass -> rsp_data=0, rsp_err=1, rsp_leds=16'hFFFF; repeated -> rsp_leds=16'h0000. red_op_A=1 with op=2 -> rsp_err=1.
- rst asserted one cycle after a handshake -> no rsp_valid for that command; all outputs 0; requester 0 is granted first after release.
